// File: rtl/key_encoder.sv
// key_encoder: 4x4 keypad scanner with debounce and key-code decode; KEY_ENCODER_REPEAT_EN adds digit auto-repeat
module key_encoder #(
    parameter int SCAN_DIV = 4,
    parameter int DEB_N    = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] KEY,
    output logic       OP,
    output logic       EQUAL,
    output logic       CLR,
    output logic       EVENT,
    output logic [1:0] STATE
);
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);
    localparam logic [7:0] DEB_LAST = 8'(DEB_N - 1);

    state_t     r_state, w_next;
    logic [3:0] r_sync1, r_sync2, r_pat, r_code, r_key, w_rows;
    logic [7:0] r_div, r_cnt, w_div, w_cnt;
    logic [1:0] r_col, w_col, w_row_idx;
    logic       r_op, r_equal, r_clr, r_event;
    logic       w_onehot, w_cap, w_press, w_rep_fire;

    assign w_rows    = r_sync2;
    assign w_onehot  = (w_rows != 4'd0) && ((w_rows & (w_rows - 4'd1)) == 4'd0);
    assign w_row_idx = {w_rows[3] | w_rows[2], w_rows[3] | w_rows[1]};
    assign w_press   = (r_state == DEBOUNCE) && (w_next == PRESSED);

    // Two-flop synchronizer for the asynchronous row sense lines
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= ROW;
            r_sync2 <= r_sync1;
        end
    end

    // Next state, column advance and shared debounce/release counter
    always_comb begin
        w_next = r_state;
        w_div  = r_div;
        w_cnt  = r_cnt;
        w_col  = r_col;
        w_cap  = 1'b0;
        case (r_state)
            SCAN: begin
                if (r_div == DIV_LAST) begin
                    w_div = '0;
                    if (w_onehot) begin
                        w_next = DEBOUNCE;
                        w_cap  = 1'b1;
                        w_cnt  = '0;
                    end else begin
                        w_col = r_col + 2'd1;
                    end
                end else begin
                    w_div = r_div + 8'd1;
                end
            end
            DEBOUNCE: begin
                if (w_rows != r_pat) begin
                    w_next = SCAN;
                    w_cnt  = '0;
                    w_col  = r_col + 2'd1;
                end else if (r_cnt == DEB_LAST) begin
                    w_next = PRESSED;
                    w_cnt  = '0;
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
            PRESSED: w_next = RELEASE;
            RELEASE: begin
                if (w_rows != 4'd0) begin
                    w_cnt = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_next = SCAN;
                    w_cnt  = '0;
                    w_col  = r_col + 2'd1;
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
        endcase
    end

    // State register, scan position and captured key pattern/code
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= SCAN;
            r_div   <= '0;
            r_cnt   <= '0;
            r_col   <= '0;
            r_pat   <= '0;
            r_code  <= '0;
        end else begin
            r_state <= w_next;
            r_div   <= w_div;
            r_cnt   <= w_cnt;
            r_col   <= w_col;
            if (w_cap) begin
                r_pat  <= w_rows;
                r_code <= {w_row_idx, r_col};
            end
        end
    end

    // Decoded outputs, updated on the edge that enters PRESSED
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_key   <= '0;
            r_op    <= 1'b0;
            r_equal <= 1'b0;
            r_clr   <= 1'b0;
            r_event <= 1'b0;
        end else begin
            r_event <= (w_press && r_code <= 4'd13) || w_rep_fire;
            r_equal <= w_press && r_code == 4'd12;
            r_clr   <= w_press && r_code == 4'd13;
            if (w_press && r_code < 4'd10)
                r_key <= r_code;
            if (w_press && (r_code == 4'd10 || r_code == 4'd11))
                r_op <= r_code[0];
        end
    end

`ifdef KEY_ENCODER_REPEAT_EN
    localparam logic [15:0] REP_FIRST  = 16'(64 * SCAN_DIV - 1);
    localparam logic [15:0] REP_RELOAD = 16'(48 * SCAN_DIV);

    logic [15:0] r_rep;

    assign w_rep_fire = (r_state == RELEASE) && (r_code < 4'd10) && (w_rows != 4'd0) && (r_rep == REP_FIRST);

    // Cycles since the original press; reloads so later repeats come every 16 column periods
    always_ff @(posedge CLK) begin
        if (RST || w_press)
            r_rep <= '0;
        else if (r_state == PRESSED || r_state == RELEASE)
            r_rep <= (r_rep == REP_FIRST) ? REP_RELOAD : r_rep + 16'd1;
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    assign COL   = 4'b0001 << r_col;
    assign KEY   = r_key;
    assign OP    = r_op;
    assign EQUAL = r_equal;
    assign CLR   = r_clr;
    assign EVENT = r_event;
    assign STATE = r_state;

endmodule

// File: doc/key_encoder.md
KEY_ENCODER -- requirements
Module: key_encoder

Interface
REQ-001 Parameter SCAN_DIV, default 4: clock cycles each column is driven during scanning; legal range 3..255.
REQ-002 Parameter DEB_N, default 3: consecutive identical synchronized samples needed to accept a press or a release; legal range 1..255.
REQ-003 Port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port RST, input, 1: reset, synchronous and active-high.
REQ-005 Port ROW, input, 4: keypad row sense lines, active-high, asynchronous to CLK.
REQ-006 Port COL, output, 4: keypad column drive, one-hot, active-high.
REQ-007 Port KEY, output, 4: digit value of the last accepted digit key.
REQ-008 Port OP, output, 1: operator of the last accepted operator key; 0 = add, 1 = multiply.
REQ-009 Port EQUAL, output, 1: '=' key event qualifier.
REQ-010 Port CLR, output, 1: 'C' key event qualifier.
REQ-011 Port EVENT, output, 1: single-cycle strobe marking an accepted key press.
REQ-012 Port STATE, output, 2: current FSM state, for debug.

Function
REQ-013 ROW shall pass through a 2-flop synchronizer; all decisions use the synchronized value ROWS.
REQ-014 Key code shall be row*4 + column: codes 0-9 digits; 10 '+'; 11 '*'; 12 '='; 13 'C'; 14-15 ignored.
REQ-015 FSM states, in STATE encoding: SCAN=0, DEBOUNCE=1, PRESSED=2, RELEASE=3.
REQ-016 In SCAN: COL rotates 0001->0010->0100->1000->0001, one step per SCAN_DIV cycles; ROWS sampled only on the last cycle of each column period.
REQ-017 SCAN -> DEBOUNCE when the sample has exactly one bit set; column frozen, pattern captured.
REQ-018 A sample with zero bits or two or more bits set shall be ignored; scanning continues.
REQ-019 In DEBOUNCE: each cycle, ROWS equal to the captured pattern increments the match counter; after DEB_N matches -> PRESSED.
REQ-020 In DEBOUNCE: any mismatch -> SCAN with the counter cleared; scanning resumes at the next column.
REQ-021 On entry to PRESSED with code 0-9: KEY is updated to the code and EVENT is high for exactly one cycle.
REQ-022 On entry to PRESSED with code 10 or 11: OP is updated (0 or 1) and EVENT is high for one cycle.
REQ-023 On entry to PRESSED with code 12: EQUAL and EVENT are high together for one cycle.
REQ-024 On entry to PRESSED with code 13: CLR and EVENT are high together for one cycle.
REQ-025 On entry to PRESSED with code 14 or 15: no output changes and no EVENT.
REQ-026 EQUAL and CLR shall never be high without EVENT.
REQ-027 KEY and OP shall hold their values between events.
REQ-028 PRESSED -> RELEASE the cycle after entry; the column stays frozen.
REQ-029 In RELEASE: DEB_N consecutive all-zero ROWS samples -> SCAN at the next column; any nonzero sample restarts the count.
REQ-030 A second key pressed while in PRESSED or RELEASE shall produce no event (no rollover).
REQ-031 Latency: EVENT asserts exactly DEB_N+1 cycles after the accepting SCAN sample.

Reset
REQ-032 While RST is high at a clock edge, the following shall take effect on that edge and override all else, including mid-debounce and an in-flight EVENT: STATE=0, COL=0001, KEY=0, OP=0, EQUAL=0, CLR=0, EVENT=0, all counters and synchronizer flops cleared.
REQ-033 The first column period after reset is full length.

Configuration
REQ-034 With macro KEY_ENCODER_REPEAT_EN defined, a digit key held in RELEASE re-strobes EVENT, with KEY unchanged, every 16*SCAN_DIV cycles, starting 64*SCAN_DIV cycles after the original EVENT.
REQ-035 With KEY_ENCODER_REPEAT_EN defined, operator, '=' and 'C' keys never auto-repeat.
REQ-036 Without KEY_ENCODER_REPEAT_EN, no repeat logic is present and REQ-029 alone governs RELEASE.

Verification (SCAN_DIV=4, DEB_N=3)
REQ-037 Hold ROW=0010 while COL=0100 (code 6) -> single EVENT with KEY=6, 4 cycles after the accepting sample; no further EVENT until release.
REQ-038 Press code 11, release, then press code 12 -> EVENT with OP=1, then EVENT with EQUAL=1; EQUAL low in all other cycles.
REQ-039 ROW bounce 0001/0000 alternating each cycle at COL=0001 for 20 cycles -> no EVENT and STATE never reaches 2.
REQ-040 ROW=0011 in one column -> ignored: no EVENT, COL keeps rotating.
REQ-041 RST pulsed in the DEBOUNCE cycle where the count reaches 2 -> no EVENT, STATE=0, COL=0001 on the next cycle.
REQ-042 With KEY_ENCODER_REPEAT_EN, hold code 3 for 400 cycles -> EVENTs at offsets 0, 256, 320 and 384 cycles, each with KEY=3.
